// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, then clocks one byte with odd parity out to
// the device under device-generated clock, checks the ack bit and bounds the whole exchange with a timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic [1:0] tx_status
);

  typedef enum logic [2:0] {IDLE, INHIBIT, SEND, ACK, WAIT_IDLE} state_t;

  localparam logic [12:0] INH_LAST = 13'(INHIBIT_CYCLES - 1);
  localparam logic [12:0] INH_DATA = 13'(INHIBIT_CYCLES - 2);
  localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [2:0]  clk_sync;   // [1:0] synchroniser, [2] previous synced value for edge detect
  logic [1:0]  data_sync;
  logic [9:0]  shift;
  logic [3:0]  idx;
  logic [12:0] icnt;
  logic [19:0] tcnt;
  logic        nack;

  logic clk_s, data_s, clk_fall;
  assign clk_s    = clk_sync[1];
  assign data_s   = data_sync[1];
  assign clk_fall = clk_sync[2] & ~clk_sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      tx_ready    <= 1'b1;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      tx_status   <= 2'd0;
      shift       <= '0;
      idx         <= '0;
      icnt        <= '0;
      tcnt        <= '0;
      nack        <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            shift      <= {1'b1, ~^tx_data, tx_data};
            state      <= INHIBIT;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            icnt       <= '0;
          end
        end
        INHIBIT: begin
          icnt <= icnt + 13'd1;
          // start bit goes low one cycle before the clock is released
          if (icnt == INH_DATA) ps2_data_oe <= 1'b1;
          if (icnt == INH_LAST) begin
            ps2_data_oe <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            tcnt        <= '0;
            idx         <= '0;
            state       <= SEND;
          end
        end
        default: begin
          tcnt <= tcnt + 20'd1;
          // timeout wins over any edge seen in the same cycle
          if (tcnt == TO_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b1;
            tx_status   <= 2'd2;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (state == SEND) begin
            if (clk_fall) begin
              ps2_data_oe <= ~shift[idx];
              idx         <= idx + 4'd1;
              if (idx == 4'd9) state <= ACK;
            end
          end else if (state == ACK) begin
            if (clk_fall) begin
              nack  <= data_s;
              state <= WAIT_IDLE;
            end
          end else if (clk_s && data_s) begin
            tx_done   <= 1'b1;
            tx_status <= {1'b0, nack};
            tx_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks the frame out and
// every observation is checked against hand-computed frames and latencies.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TO  = 2000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done;
  logic [1:0] tx_status;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  // open-drain bus: either side pulling low wins
  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
    .tx_done(tx_done), .tx_status(tx_status)
  );

  always #10 clk = ~clk;

  int ncmp = 0, nerr = 0;
  int oe_hi = 0, inv_bad = 0;

  always @(negedge clk) begin
    if (ps2_clk_oe === 1'b1) oe_hi++;
    if (busy === tx_ready) inv_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_release();
    int k = 0;
    while (ps2_clk_oe !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("clk_release_seen", k < 200, 1'b1);
  endtask

  logic [9:0] got;
  logic       early;
  logic       prev_busy;

  // device side: 11 falling edges, data sampled before each rising edge
  task automatic dev_xfer(input bit ack, input int hold11, input int abort_at);
    got   = '0;
    early = 1'b0;
    wait_release();
    chk("start_bit_oe", ps2_data_oe, 1'b1);
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && ack) dev_data_low = 1'b1;
      tick(2);
      dev_clk_low = 1'b1;
      if (i == abort_at) begin
        tick(5);
        return;
      end
      if (i == 11) begin
        for (int h = 0; h < 10 + hold11; h++) begin
          @(negedge clk);
          if (tx_done === 1'b1) early = 1'b1;
        end
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        return;
      end
      tick(10);
      got[i-1]    = ps2_data_line;
      dev_clk_low = 1'b0;
      tick(8);
    end
  endtask

  task automatic wait_done(input int max, output int lat);
    lat = -1;
    for (int k = 1; k <= max; k++) begin
      prev_busy = busy;
      @(negedge clk);
      if (tx_done === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("done_seen", lat > 0, 1'b1);
  endtask

  initial begin
    int lat, oe0, inv0;

    // reset state
    tick(3);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_clk_oe", ps2_clk_oe, 1'b0);
    chk("rst_data_oe", ps2_data_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_status", tx_status, 2'd0);
    reset_n = 1'b1;
    tick(2);

    // 0xED: parity 1, ack ok, inhibit length
    oe0 = oe_hi;
    send(8'hED);
    chk("ed_ready_low", tx_ready, 1'b0);
    chk("ed_clk_oe", ps2_clk_oe, 1'b1);
    chk("ed_busy", busy, 1'b1);
    dev_xfer(1'b1, 0, 0);
    chk("ed_inhibit_len", oe_hi - oe0, INH);
    chk("ed_frame", got, 10'h3ED);
    wait_done(100, lat);
    chk("ed_status", tx_status, 2'd0);
    chk("ed_ready_at_done", tx_ready, 1'b1);

    // 0xF4: parity 0, busy/ready behaviour
    tick(3);
    inv0 = inv_bad;
    send(8'hF4);
    dev_xfer(1'b1, 0, 0);
    chk("f4_frame", got, 10'h2F4);
    wait_done(100, lat);
    chk("f4_status", tx_status, 2'd0);
    chk("f4_busy_before_done", prev_busy, 1'b1);
    tick(1);
    chk("f4_busy_after_done", busy, 1'b0);
    chk("f4_busy_ready_excl", inv_bad - inv0, 0);

    // silent device: timeout
    tick(3);
    send(8'hFF);
    wait_release();
    wait_done(TO + 100, lat);
    chk("to_latency", lat, TO);
    chk("to_status", tx_status, 2'd2);
    chk("to_clk_oe", ps2_clk_oe, 1'b0);
    chk("to_data_oe", ps2_data_oe, 1'b0);

    // no ack, and lines held busy afterwards
    tick(3);
    send(8'h12);
    dev_xfer(1'b0, 60, 0);
    chk("nack_frame", got, 10'h312);
    chk("nack_no_early_done", early, 1'b0);
    wait_done(100, lat);
    chk("nack_status", tx_status, 2'd1);

    // reset mid-frame at edge 5 (D4 of 0xED is 0, so data is being driven)
    tick(3);
    send(8'hED);
    dev_xfer(1'b1, 0, 5);
    chk("abort_pre_drive", ps2_data_oe, 1'b1);
    #3;
    reset_n      = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    #1;
    chk("abort_clk_oe", ps2_clk_oe, 1'b0);
    chk("abort_data_oe", ps2_data_oe, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(2);
    chk("abort_ready", tx_ready, 1'b1);
    chk("abort_status_cleared", tx_status, 2'd0);
    chk("abort_no_done", tx_done, 1'b0);
    send(8'h00);
    dev_xfer(1'b1, 0, 0);
    chk("zero_frame", got, 10'h300);
    wait_done(100, lat);
    chk("zero_status", tx_status, 2'd0);

    // tx_valid held: one byte per IDLE visit, second starts on tx_done
    tick(3);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    @(negedge clk);
    chk("b2b_first_accept", tx_ready, 1'b0);
    tx_data = 8'h3C;
    dev_xfer(1'b1, 0, 0);
    chk("b2b_frame1", got, 10'h35A);
    wait_done(100, lat);
    chk("b2b_ready_at_done", tx_ready, 1'b1);
    @(negedge clk);
    chk("b2b_second_accept", tx_ready, 1'b0);
    chk("b2b_second_clk_oe", ps2_clk_oe, 1'b1);
    tx_valid = 1'b0;
    dev_xfer(1'b1, 0, 0);
    chk("b2b_frame2", got, 10'h33C);
    wait_done(100, lat);
    chk("b2b_status", tx_status, 2'd0);
    tick(5);
    chk("b2b_no_third", ps2_clk_oe, 1'b0);
    chk("b2b_idle", tx_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
